friscv_icache_rd_arbiter: RTL

- Shares the single AXI4 read port to central memory between two requesters:
  - requester 0: icache fetcher miss path (memctrl_ar* of the fetcher);
  - requester 1: the icache prefetcher.
- Read-address channel: round-robin arbitration behind a registered AR stage.
- Read-data channel: in-order route FIFO steers R beats back to the requester that issued the request.
- Sits between the icache fetcher/prefetcher and the icache memory controller.

---
 rtl/friscv_icache_rd_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/friscv_icache_rd_arbiter.sv
// friscv_icache_rd_arbiter: round-robin share of one AXI4 read port between icache fetcher and prefetcher
module friscv_icache_rd_arbiter #(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 4
)(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [AXI_ADDR_W-1:0] s0_araddr,
  input  logic [2:0]            s0_arprot,
  input  logic [AXI_ID_W-1:0]   s0_arid,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [AXI_ID_W-1:0]   s0_rid,
  output logic [1:0]            s0_rresp,
  output logic [AXI_DATA_W-1:0] s0_rdata,
  output logic                  s0_rlast,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [AXI_ADDR_W-1:0] s1_araddr,
  input  logic [2:0]            s1_arprot,
  input  logic [AXI_ID_W-1:0]   s1_arid,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [AXI_ID_W-1:0]   s1_rid,
  output logic [1:0]            s1_rresp,
  output logic [AXI_DATA_W-1:0] s1_rdata,
  output logic                  s1_rlast,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [AXI_ADDR_W-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic [AXI_ID_W-1:0]   m_arid,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [AXI_ID_W-1:0]   m_rid,
  input  logic [1:0]            m_rresp,
  input  logic [AXI_DATA_W-1:0] m_rdata,
  input  logic                  m_rlast,
  output logic                  busy
);
  localparam int PW = $clog2(OSTDREQ_NUM);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d;
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OSTDREQ_NUM-1:0] route_q, route_d;
  logic m_arvalid_q, m_arvalid_d;
  logic [AXI_ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [2:0] m_arprot_q, m_arprot_d;
  logic [AXI_ID_W-1:0] m_arid_q, m_arid_d;
  logic empty, full, grant, win, head, pop;
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q - rptr_q) == (PW+1)'(OSTDREQ_NUM);
  assign grant = state_q == IDLE && !full && !srst && (s0_arvalid || s1_arvalid);
  assign win   = (s0_arvalid && s1_arvalid) ? rr_q : s1_arvalid;
  assign s0_arready = grant & ~win;
  assign s1_arready = grant & win;
  assign head = route_q[rptr_q[PW-1:0]];
  assign s0_rvalid = m_rvalid & ~empty & ~head;
  assign s1_rvalid = m_rvalid & ~empty & head;
  assign m_rready  = ~empty & (head ? s1_rready : s0_rready);
  assign pop = m_rvalid & m_rready & m_rlast;
  assign s0_rid   = m_rid;
  assign s1_rid   = m_rid;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;
  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arprot  = m_arprot_q;
  assign m_arid    = m_arid_q;
  assign busy = state_q != IDLE || !empty;
  // Next state: arbitrate in IDLE, hold the AR stage in REQ, track route FIFO; srst forces reset values
  always_comb begin
    state_d = state_q == IDLE ? (grant ? REQ : IDLE) : (m_arready ? IDLE : REQ);
    rr_d = grant ? ~win : rr_q;
    wptr_d = wptr_q + (PW+1)'(grant);
    rptr_d = rptr_q + (PW+1)'(pop);
    route_d = route_q;
    if (grant) route_d[wptr_q[PW-1:0]] = win;
    m_araddr_d = grant ? (win ? s1_araddr : s0_araddr) : m_araddr_q;
    m_arprot_d = grant ? (win ? s1_arprot : s0_arprot) : m_arprot_q;
    m_arid_d = grant ? (win ? s1_arid : s0_arid) : m_arid_q;
    if (srst) begin
      state_d = IDLE;
      rr_d = 1'b0;
      wptr_d = '0;
      rptr_d = '0;
      route_d = '0;
      m_araddr_d = '0;
      m_arprot_d = '0;
      m_arid_d = '0;
    end
    m_arvalid_d = state_d == REQ;
  end
  // State and registered AR outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      route_q <= '0;
      m_arvalid_q <= 1'b0;
      m_araddr_q <= '0;
      m_arprot_q <= '0;
      m_arid_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      route_q <= route_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q <= m_araddr_d;
      m_arprot_q <= m_arprot_d;
      m_arid_q <= m_arid_d;
    end
  end
endmodule
